i2s_frame_sched: RTL and testbench
==================================

// Module: i2s_frame_sched
// PURPOSE
//  Timing master and sample scheduler for the I2S transmit path.
//  - Derives mclk, sclk and lrck levels from the system clock.
//  - Buffers one stereo frame from an AXI-stream source.
//  - Issues the per-channel load strobe and payload to the i2s_tx serializer.
//  Sits between the effects pipeline output stream and i2s_tx, and is the only
//  source of audio clocks in the design.
// PARAMETERS
//  DATA_WIDTH   24  sample payload bits per channel
//  MCLK_HALF    4   clk cycles per mclk half-period (>=1)
//  SCLK_RATIO   4   mclk periods per sclk period (>=1)
//  BITS_PER_CH  32  sclk periods per channel slot (>=DATA_WIDTH)
//  Derived: P = 2*MCLK_HALF*SCLK_RATIO clk/sclk period; F = 2*BITS_PER_CH*P clk/frame
// PORTS
//  clk       in   1           system clock
//  rst       in   1           synchronous active-high reset
//  en        in   1           run enable; 0 = hold idle
//  s_tdata   in   DATA_WIDTH  stream sample
//  s_tvalid  in   1           stream valid
//  s_tlast   in   1           1 = right-channel beat, 0 = left-channel beat
//  s_tready  out  1           stream ready
//  mclk      out  1           master clock level
//  sclk      out  1           serial bit clock level
//  lrck      out  1           word select: 0 left, 1 right
//  tx_load   out  1           1-cycle strobe: tx_data valid for new channel slot
//  tx_chan   out  1           channel of tx_data (0 L, 1 R)
//  tx_data   out  DATA_WIDTH  sample for serializer
//  underrun  out  1           1-cycle pulse: frame boundary with no buffered frame
//  sync_err  out  1           1-cycle pulse: tlast out of L/R order
// BEHAVIOUR
//  Reset / en=0:
//  - Every output is 0; pos=0; FSM=IDLE; frame buffers cleared.
//  - en falling mid-frame behaves identically on the next edge. Clocks stop low.
//  Timebase:
//  - pos counts 0..F-1 while en=1, wraps to 0. Let q = pos mod P, b = pos / P.
//  - mclk = (pos mod 2*MCLK_HALF) >= MCLK_HALF.
//  - sclk = q >= P/2, so the sclk falling edge is at q=0.
//  - lrck = b >= BITS_PER_CH.
//  - All three outputs are registered decodes of pos and appear 1 cycle after
//    the pos value.
//  - tx_load pulses in the same cycle lrck changes level, i.e. the decode of
//    pos=0 (left) and pos=BITS_PER_CH*P (right). tx_chan equals the new lrck.
//    The 1-sclk I2S MSB delay is applied in i2s_tx, not here.
//  Buffering:
//  - Two-stage buffering: a fetch pair (fl, fr) and an output pair (ol, or).
//  - FSM states and transitions:
//    - IDLE: entered on rst or en=0. Goes to FETCH_L when en=1.
//    - FETCH_L: s_tready=1. On a beat with tlast=0: fl<=tdata, go to FETCH_R.
//      On a beat with tlast=1: drop it, pulse sync_err, stay.
//    - FETCH_R: s_tready=1. On a beat with tlast=1: fr<=tdata, go to FULL.
//      On a beat with tlast=0: fl<=tdata, pulse sync_err, stay (resync to the
//      newer left sample).
//    - FULL: s_tready=0; wait for the frame boundary.
//  - Frame boundary is the cycle where pos wraps to 0:
//    - If FULL: ol<=fl, or<=fr, go to FETCH_L.
//    - Otherwise: ol<=0, or<=0, pulse underrun. Fetch state is unchanged, so a
//      partial frame is kept.
//  - Simultaneous boundary and accepting right beat (FETCH_R): the beat is
//    captured, the frame counts as not ready, underrun fires, and the next
//    state is FULL.
//  - tx_data = ol on the left load, or on the right load. It holds between
//    loads.
//  - The first frame after enable always plays zeros (pipeline fill).
//  - s_tready is a registered state decode. There is no combinational path
//    from s_tvalid.
// TESTING
//  Bench parameters: DATA_WIDTH=8, MCLK_HALF=1, SCLK_RATIO=2, BITS_PER_CH=4,
//  giving P=4 and F=32.
//  1 Reset, then en=1 for 64 cycles -> mclk period 2, sclk period 4, lrck
//    period 32; the first rise follows pos=16 by 1 cycle; tx_load every 16
//    cycles with tx_chan alternating 0,1.
//  2 Stream beats (0x11,tlast0) and (0x22,tlast1) before the first wrap ->
//    first frame loads 0x00/0x00; second frame loads tx_data=0x11 (chan 0),
//    then 0x22 (chan 1).
//  3 No stream input for 3 frames -> underrun pulses once per wrap; tx_data=0
//    at each load; s_tready stays 1.
//  4 Beats (0xAA,tlast1), (0x33,0), (0x44,0), (0x55,1) -> sync_err pulses on
//    0xAA and 0x44; the next frame plays 0x44/0x55.
//  5 en deasserted at pos=20 -> next cycle all outputs 0 and s_tready=0;
//    re-enable gives lrck low and a tx_load 1 cycle later with data 0.
//  6 Continuous valid stream of L/R pairs 0x01..0x0A -> back-pressure holds
//    s_tready=0 in FULL; no sample lost or repeated; no underrun after the
//    first frame.

Source files
------------

// File: rtl/i2s_frame_sched_if.sv
// i2s_frame_sched_if: AXI-stream sample port feeding the I2S frame scheduler
interface i2s_frame_sched_if #(parameter int DATA_WIDTH = 24);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;
    modport master (output tdata, tvalid, tlast, input tready);
    modport slave (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/i2s_frame_sched.sv
// i2s_frame_sched: audio clock master and stereo frame scheduler for i2s_tx
module i2s_frame_sched #(
    parameter int DATA_WIDTH  = 24,
    parameter int MCLK_HALF   = 4,
    parameter int SCLK_RATIO  = 4,
    parameter int BITS_PER_CH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    i2s_frame_sched_if.slave      s,
    output logic                  o_mclk,
    output logic                  o_sclk,
    output logic                  o_lrck,
    output logic                  o_tx_load,
    output logic                  o_tx_chan,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_underrun,
    output logic                  o_sync_err
);
    localparam int P  = 2 * MCLK_HALF * SCLK_RATIO;
    localparam int MW = $clog2(2 * MCLK_HALF);
    localparam int QW = $clog2(P);
    localparam int BW = $clog2(2 * BITS_PER_CH);
    localparam logic [MW-1:0] M_LAST = MW'(2 * MCLK_HALF - 1);
    localparam logic [MW-1:0] M_HALF = MW'(MCLK_HALF);
    localparam logic [QW-1:0] Q_LAST = QW'(P - 1);
    localparam logic [QW-1:0] Q_HALF = QW'(P / 2);
    localparam logic [BW-1:0] B_LAST = BW'(2 * BITS_PER_CH - 1);
    localparam logic [BW-1:0] B_HALF = BW'(BITS_PER_CH);

    typedef enum logic [1:0] {IDLE, FETCH_L, FETCH_R, FULL} state_t;

    state_t                r_state;
    logic                  r_tready;
    logic [MW-1:0]         r_m;
    logic [QW-1:0]         r_q;
    logic [BW-1:0]         r_b;
    logic [DATA_WIDTH-1:0] r_fl, r_fr, r_ol, r_or;
    logic                  w_beat, w_wrap, w_right, w_load, w_full;

    // pos is held as three sub-counters (mclk phase, q, b) so no divider is needed
    assign s.tready = r_tready;
    assign w_beat   = s.tvalid && r_tready;
    assign w_wrap   = r_q == Q_LAST && r_b == B_LAST;
    assign w_right  = r_b == B_HALF;
    assign w_load   = r_q == '0 && (r_b == '0 || w_right);
    assign w_full   = r_state == FULL;

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_state    <= IDLE;
            r_tready   <= 1'b0;
            r_m        <= '0;
            r_q        <= '0;
            r_b        <= '0;
            r_fl       <= '0;
            r_fr       <= '0;
            r_ol       <= '0;
            r_or       <= '0;
            o_mclk     <= 1'b0;
            o_sclk     <= 1'b0;
            o_lrck     <= 1'b0;
            o_tx_load  <= 1'b0;
            o_tx_chan  <= 1'b0;
            o_tx_data  <= '0;
            o_underrun <= 1'b0;
            o_sync_err <= 1'b0;
        end else begin
            r_m <= r_m == M_LAST ? '0 : r_m + 1'b1;
            r_q <= r_q == Q_LAST ? '0 : r_q + 1'b1;
            if (r_q == Q_LAST)
                r_b <= r_b == B_LAST ? '0 : r_b + 1'b1;
            o_mclk    <= r_m >= M_HALF;
            o_sclk    <= r_q >= Q_HALF;
            o_lrck    <= r_b >= B_HALF;
            o_tx_load <= w_load;
            if (w_load) begin
                o_tx_chan <= w_right;
                o_tx_data <= w_right ? r_or : r_ol;
            end
            o_underrun <= w_wrap && !w_full;
            o_sync_err <= w_beat && (s.tlast ? r_state == FETCH_L : r_state == FETCH_R);
            // a right beat landing on the boundary is captured but plays one frame later
            if (w_wrap) begin
                r_ol <= w_full ? r_fl : '0;
                r_or <= w_full ? r_fr : '0;
            end
            if (w_beat && !s.tlast)
                r_fl <= s.tdata;
            if (w_beat && s.tlast && r_state == FETCH_R)
                r_fr <= s.tdata;
            case (r_state)
                IDLE: begin
                    r_state  <= FETCH_L;
                    r_tready <= 1'b1;
                end
                FETCH_L: if (w_beat && !s.tlast) r_state <= FETCH_R;
                FETCH_R: if (w_beat && s.tlast) begin
                    r_state  <= FULL;
                    r_tready <= 1'b0;
                end
                default: if (w_wrap) begin
                    r_state  <= FETCH_L;
                    r_tready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2s_frame_sched.sv
// tb_i2s_frame_sched: directed and random stimulus checked against a frame-level reference model
module tb_i2s_frame_sched;
    localparam int DW = 8, MH = 1, SR = 2, BPC = 4;
    localparam int P = 2 * MH * SR, F = 2 * BPC * P;

    logic          clk, rst, en;
    logic          mclk, sclk, lrck, tx_load, tx_chan, underrun, sync_err;
    logic [DW-1:0] tx_data;

    i2s_frame_sched_if #(.DATA_WIDTH(DW)) ifc ();

    i2s_frame_sched #(.DATA_WIDTH(DW), .MCLK_HALF(MH), .SCLK_RATIO(SR), .BITS_PER_CH(BPC)) dut (
        .clk(clk), .rst(rst), .i_en(en), .s(ifc),
        .o_mclk(mclk), .o_sclk(sclk), .o_lrck(lrck), .o_tx_load(tx_load),
        .o_tx_chan(tx_chan), .o_tx_data(tx_data), .o_underrun(underrun), .o_sync_err(sync_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int n_tot = 0, n_bad = 0;
    int n_under = 0, n_sync = 0;
    logic [8:0] q_loads[$];

    // reference: frame position plus a partial/complete pending frame and the playing frame
    int            m_pos = 0;
    logic          m_have_l = 0, m_full = 0;
    logic [DW-1:0] m_fl = 0, m_fr = 0, m_ol = 0, m_or = 0;
    logic          e_mclk = 0, e_sclk = 0, e_lrck = 0, e_load = 0, e_chan = 0;
    logic          e_under = 0, e_sync = 0, e_ready = 0;
    logic [DW-1:0] e_data = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_step;
        logic beat, wrap, ld;
        if (rst || !en) begin
            m_pos = 0; m_have_l = 0; m_full = 0;
            m_fl = 0; m_fr = 0; m_ol = 0; m_or = 0;
            e_mclk = 0; e_sclk = 0; e_lrck = 0; e_load = 0; e_chan = 0;
            e_data = 0; e_under = 0; e_sync = 0; e_ready = 0;
        end else begin
            e_mclk = (m_pos % (2 * MH)) >= MH;
            e_sclk = (m_pos % P) >= P / 2;
            e_lrck = (m_pos / P) >= BPC;
            ld = m_pos == 0 || m_pos == BPC * P;
            e_load = ld;
            if (ld) begin
                e_chan = m_pos != 0;
                e_data = m_pos == 0 ? m_ol : m_or;
            end
            beat = ifc.tvalid && e_ready;
            wrap = m_pos == F - 1;
            e_under = wrap && !m_full;
            if (wrap) begin
                m_ol = m_full ? m_fl : 0;
                m_or = m_full ? m_fr : 0;
                if (m_full) begin
                    m_full = 0;
                    m_have_l = 0;
                end
            end
            e_sync = 0;
            if (beat) begin
                if (!ifc.tlast) begin
                    e_sync = m_have_l;
                    m_fl = ifc.tdata;
                    m_have_l = 1;
                end else if (!m_have_l) begin
                    e_sync = 1;
                end else begin
                    m_fr = ifc.tdata;
                    m_full = 1;
                end
            end
            e_ready = !m_full;
            m_pos = (m_pos + 1) % F;
        end
    endtask

    function automatic int act_vec();
        return int'({mclk, sclk, lrck, tx_load, tx_chan, tx_data, underrun, sync_err, ifc.tready});
    endfunction

    function automatic int exp_vec();
        return int'({e_mclk, e_sclk, e_lrck, e_load, e_chan, e_data, e_under, e_sync, e_ready});
    endfunction

    task automatic tick;
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk($sformatf("outputs@%0t", $time), act_vec(), exp_vec());
        if (tx_load) q_loads.push_back({tx_chan, tx_data});
        n_under += int'(underrun);
        n_sync += int'(sync_err);
    endtask

    task automatic restart;
        ifc.tvalid = 0;
        rst = 1;
        en = 0;
        tick();
        tick();
        rst = 0;
        en = 1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        int n = 0;
        ifc.tdata = d;
        ifc.tlast = l;
        ifc.tvalid = 1;
        while (!ifc.tready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_tot++;
            n_bad++;
            $display("FAIL send_timeout: tready still %0b after %0d cycles", ifc.tready, n);
        end
        tick();
        ifc.tvalid = 0;
    endtask

    task automatic wait_loads(input int want);
        int n = 0;
        while (q_loads.size() < want && n < 400) begin
            tick();
            n++;
        end
        chk("load_wait", q_loads.size() >= want, 1);
    endtask

    initial begin
        int st, su, ss, rise, mr, sr_, low;
        logic pm, ps;
        ifc.tdata = 0; ifc.tvalid = 0; ifc.tlast = 0;
        rst = 1; en = 0;
        repeat (3) tick();
        chk("reset_outputs", act_vec(), 0);

        // free-running clocks and load cadence
        restart();
        st = q_loads.size(); rise = -1; mr = 0; sr_ = 0; pm = 0; ps = 0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (lrck && rise < 0) rise = k;
            if (mclk && !pm) mr++;
            if (sclk && !ps) sr_++;
            pm = mclk; ps = sclk;
        end
        chk("t1_lrck_rise", rise, 17);
        chk("t1_mclk_rises", mr, 32);
        chk("t1_sclk_rises", sr_, 16);
        chk("t1_loads", q_loads.size() - st, 4);
        for (int i = 0; i < 4; i++) chk("t1_chan", int'(q_loads[st + i][8]), i % 2);

        // first frame plays zeros, second plays the buffered pair
        restart();
        st = q_loads.size();
        send(8'h11, 0);
        send(8'h22, 1);
        wait_loads(st + 4);
        chk("t2_load0", q_loads[st], 9'h000);
        chk("t2_load1", q_loads[st + 1], 9'h100);
        chk("t2_load2", q_loads[st + 2], 9'h011);
        chk("t2_load3", q_loads[st + 3], 9'h122);

        // starved source
        restart();
        st = q_loads.size(); su = n_under; low = 0;
        repeat (96) begin
            tick();
            if (!ifc.tready) low++;
        end
        chk("t3_underruns", n_under - su, 3);
        chk("t3_ready_low", low, 0);
        chk("t3_loads", q_loads.size() - st, 6);
        for (int i = 0; i < 6; i++) chk("t3_load_zero", int'(q_loads[st + i][7:0]), 0);

        // out-of-order tlast and resync
        restart();
        st = q_loads.size(); ss = n_sync;
        send(8'hAA, 1);
        send(8'h33, 0);
        send(8'h44, 0);
        send(8'h55, 1);
        wait_loads(st + 4);
        chk("t4_sync_errs", n_sync - ss, 2);
        chk("t4_load2", q_loads[st + 2], 9'h044);
        chk("t4_load3", q_loads[st + 3], 9'h155);

        // disable mid-frame, then re-enable
        restart();
        repeat (20) tick();
        en = 0;
        tick();
        chk("t5_off", act_vec(), 0);
        en = 1;
        tick();
        chk("t5_reenable", int'({lrck, tx_load, tx_data}), 9'h100);

        // continuous stream under back-pressure
        restart();
        st = q_loads.size(); su = n_under;
        for (int i = 1; i <= 10; i++) send(DW'(i), logic'(i % 2 == 0));
        wait_loads(st + 12);
        chk("t6_underruns", n_under - su, 0);
        for (int i = 0; i < 12; i++)
            chk($sformatf("t6_load%0d", i), q_loads[st + i], {1'(i % 2), DW'(i < 2 ? 0 : i - 1)});

        // random traffic, tlast order, enables and resets
        restart();
        for (int i = 0; i < 3000; i++) begin
            ifc.tvalid = $urandom_range(0, 3) != 0;
            ifc.tlast = 1'($urandom_range(0, 1));
            ifc.tdata = DW'($urandom);
            en = $urandom_range(0, 199) != 0;
            rst = $urandom_range(0, 499) == 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
